// File: rtl/ddr3_timing_checker.sv
`default_nettype none
// ============================================================================
//  Module      : ddr3_timing_checker
//  Description : Memory-side monitor for the DDR3 command bus. Decodes every
//                command, tracks per-bank open/closed state and the cycles
//                elapsed since each relevant command. Flags any command that
//                breaks tRCD/tRP/tRAS/tRFC/tMRD/tCCD or a bank-state rule.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i          command-bus clock
//    rst_ni         asynchronous active-low reset
//    en_i           1 = decode and check commands, 0 = ignore commands
//    cs_n_i         chip select (active low)
//    ras_n_i        row strobe (active low)
//    cas_n_i        column strobe (active low)
//    we_n_i         write enable (active low)
//    ba_i[2:0]      bank address
//    a10_i          address bit 10 (PRE: 1 = precharge all)
//    viol_o         one-cycle violation pulse
//    viol_code_o    violation code, valid with viol_o
//    viol_bank_o    offending bank, valid with viol_o
//    viol_count_o   saturating count of violating commands since reset
// ============================================================================
module ddr3_timing_checker #(
    parameter int T_RCD = 5,
    parameter int T_RP  = 5,
    parameter int T_RAS = 15,
    parameter int T_RFC = 44,
    parameter int T_MRD = 4,
    parameter int T_CCD = 4,
    parameter int CNT_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        cs_n_i,
    input  logic        ras_n_i,
    input  logic        cas_n_i,
    input  logic        we_n_i,
    input  logic [2:0]  ba_i,
    input  logic        a10_i,
    output logic        viol_o,
    output logic [3:0]  viol_code_o,
    output logic [2:0]  viol_bank_o,
    output logic [15:0] viol_count_o
);

    localparam int NB = 8;
    localparam logic [CNT_W-1:0] C_RCD = CNT_W'(T_RCD);
    localparam logic [CNT_W-1:0] C_RP  = CNT_W'(T_RP);
    localparam logic [CNT_W-1:0] C_RAS = CNT_W'(T_RAS);
    localparam logic [CNT_W-1:0] C_RFC = CNT_W'(T_RFC);
    localparam logic [CNT_W-1:0] C_MRD = CNT_W'(T_MRD);
    localparam logic [CNT_W-1:0] C_CCD = CNT_W'(T_CCD);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    // Bank state is a bitmap: bit b set = bank b ACTIVE, clear = IDLE.
    logic [NB-1:0]    open_q, open_d;
    logic [CNT_W-1:0] since_act_q [NB];
    logic [CNT_W-1:0] since_act_d [NB];
    logic [CNT_W-1:0] since_pre_q [NB];
    logic [CNT_W-1:0] since_pre_d [NB];
    logic [CNT_W-1:0] since_ref_q, since_ref_d;
    logic [CNT_W-1:0] since_mrs_q, since_mrs_d;
    logic [CNT_W-1:0] since_cas_q, since_cas_d;
    logic             viol_q;
    logic [3:0]       code_q, code_d;
    logic [2:0]       bank_q, bank_d;
    logic [15:0]      count_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + C_ONE;
    endfunction

    logic       cmd_v;
    logic [2:0] op;
    logic       trp_any, tras_any;
    logic [2:0] trp_bank, tras_bank;

    assign cmd_v = en_i & ~cs_n_i;
    assign op    = {ras_n_i, cas_n_i, we_n_i};

    // Lowest-numbered bank failing tRP (for REF) and lowest ACTIVE bank failing
    // tRAS (for PRE-all). Scanning downward lets the lowest index win.
    always_comb begin
        trp_any   = 1'b0;
        trp_bank  = 3'd0;
        tras_any  = 1'b0;
        tras_bank = 3'd0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (since_pre_q[i] < C_RP) begin
                trp_any  = 1'b1;
                trp_bank = 3'(i);
            end
            if (open_q[i] && (since_act_q[i] < C_RAS)) begin
                tras_any  = 1'b1;
                tras_bank = 3'(i);
            end
        end
    end

    // Checks use pre-update counter values; the command is always assumed
    // executed, so state and counters update regardless of any violation.
    // Within each command the tests are ordered so the lowest code wins.
    always_comb begin
        open_d      = open_q;
        since_ref_d = sat_inc(since_ref_q);
        since_mrs_d = sat_inc(since_mrs_q);
        since_cas_d = sat_inc(since_cas_q);
        for (int i = 0; i < NB; i++) begin
            since_act_d[i] = sat_inc(since_act_q[i]);
            since_pre_d[i] = sat_inc(since_pre_q[i]);
        end
        code_d = 4'd0;
        bank_d = 3'd0;

        if (cmd_v) begin
            unique case (op)
                3'b011: begin // ACT
                    if (open_q[ba_i])                    code_d = 4'd1;
                    else if (since_pre_q[ba_i] < C_RP)   code_d = 4'd2;
                    else if (since_ref_q < C_RFC)        code_d = 4'd3;
                    else if (since_mrs_q < C_MRD)        code_d = 4'd4;
                    bank_d              = ba_i;
                    open_d[ba_i]        = 1'b1;
                    since_act_d[ba_i]   = C_ONE;
                end
                3'b101, 3'b100: begin // RD / WR
                    if (!open_q[ba_i])                   code_d = 4'd5;
                    else if (since_act_q[ba_i] < C_RCD)  code_d = 4'd6;
                    else if (since_cas_q < C_CCD)        code_d = 4'd7;
                    bank_d      = ba_i;
                    since_cas_d = C_ONE;
                end
                3'b010: begin // PRE
                    if (a10_i) begin
                        if (tras_any) begin
                            code_d = 4'd8;
                            bank_d = tras_bank;
                        end
                        for (int i = 0; i < NB; i++) begin
                            if (open_q[i]) since_pre_d[i] = C_ONE;
                        end
                        open_d = '0;
                    end else begin
                        bank_d = ba_i;
                        // PRE to an IDLE bank is a legal no-op.
                        if (open_q[ba_i]) begin
                            if (since_act_q[ba_i] < C_RAS) code_d = 4'd8;
                            open_d[ba_i]      = 1'b0;
                            since_pre_d[ba_i] = C_ONE;
                        end
                    end
                end
                3'b001: begin // REF
                    if (trp_any) begin
                        code_d = 4'd2;
                        bank_d = trp_bank;
                    end
                    else if (since_ref_q < C_RFC)        code_d = 4'd3;
                    else if (|open_q)                    code_d = 4'd9;
                    since_ref_d = C_ONE;
                end
                3'b000: begin // MRS
                    if (since_mrs_q < C_MRD)             code_d = 4'd4;
                    else if (|open_q)                    code_d = 4'd10;
                    since_mrs_d = C_ONE;
                end
                default: ; // NOP, ZQ
            endcase
        end

        // Bank is only meaningful alongside a violation.
        if (code_d == 4'd0) bank_d = 3'd0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            open_q      <= '0;
            since_ref_q <= '1;
            since_mrs_q <= '1;
            since_cas_q <= '1;
            for (int i = 0; i < NB; i++) begin
                since_act_q[i] <= '1;
                since_pre_q[i] <= '1;
            end
            viol_q  <= 1'b0;
            code_q  <= 4'd0;
            bank_q  <= 3'd0;
            count_q <= 16'd0;
        end else begin
            open_d_to_q: begin
                open_q      <= open_d;
                since_ref_q <= since_ref_d;
                since_mrs_q <= since_mrs_d;
                since_cas_q <= since_cas_d;
                for (int i = 0; i < NB; i++) begin
                    since_act_q[i] <= since_act_d[i];
                    since_pre_q[i] <= since_pre_d[i];
                end
            end
            viol_q <= (code_d != 4'd0);
            code_q <= code_d;
            bank_q <= bank_d;
            if ((code_d != 4'd0) && (count_q != 16'hFFFF)) count_q <= count_q + 16'd1;
        end
    end

    assign viol_o       = viol_q;
    assign viol_code_o  = code_q;
    assign viol_bank_o  = bank_q;
    assign viol_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_timing_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr3_timing_checker
//  Description : Directed self-checking bench for ddr3_timing_checker.
//                Commands are driven on the falling edge, sampled by the DUT
//                on the next rising edge, and outputs checked on the
//                following falling edge. Edge offsets quoted below are counted
//                between the rising edges that sample the two commands.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_timing_checker;

    localparam logic [2:0] OP_ACT = 3'b011;
    localparam logic [2:0] OP_RD  = 3'b101;
    localparam logic [2:0] OP_WR  = 3'b100;
    localparam logic [2:0] OP_PRE = 3'b010;
    localparam logic [2:0] OP_REF = 3'b001;
    localparam logic [2:0] OP_MRS = 3'b000;

    logic        clk, rst_n, en, cs_n, ras_n, cas_n, we_n, a10;
    logic [2:0]  ba;
    logic        viol;
    logic [3:0]  viol_code;
    logic [2:0]  viol_bank;
    logic [15:0] viol_count;

    int n_cmp = 0;
    int n_err = 0;

    ddr3_timing_checker dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .cs_n_i       (cs_n),
        .ras_n_i      (ras_n),
        .cas_n_i      (cas_n),
        .we_n_i       (we_n),
        .ba_i         (ba),
        .a10_i        (a10),
        .viol_o       (viol),
        .viol_code_o  (viol_code),
        .viol_bank_o  (viol_bank),
        .viol_count_o (viol_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [3:0] c,
                              input logic [2:0] b, input logic [15:0] n);
        chk({tag, ".viol"},  32'(viol),       32'(v));
        chk({tag, ".code"},  32'(viol_code),  32'(c));
        chk({tag, ".bank"},  32'(viol_bank),  32'(b));
        chk({tag, ".count"}, 32'(viol_count), 32'(n));
    endtask

    // Drive one command for exactly one rising edge, then return to NOP.
    task automatic cmd(input logic [2:0] op, input logic [2:0] b, input logic a, input logic e);
        cs_n = 1'b0;
        {ras_n, cas_n, we_n} = op;
        ba  = b;
        a10 = a;
        en  = e;
        @(negedge clk);
        cs_n = 1'b1;
        {ras_n, cas_n, we_n} = 3'b111;
        ba  = 3'd0;
        a10 = 1'b0;
        en  = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; cs_n = 1'b1;
        {ras_n, cas_n, we_n} = 3'b111; ba = 3'd0; a10 = 1'b0;
        idle(2);
        expect_out("reset", 1'b0, 4'd0, 3'd0, 16'd0);
        rst_n = 1'b1;
        idle(1);

        // 1: legal ACT/RD/PRE/ACT/PRE on bank 3
        cmd(OP_ACT, 3'd3, 1'b0, 1'b1);  expect_out("t1.act",  1'b0, 4'd0, 3'd0, 16'd0);
        idle(4); cmd(OP_RD,  3'd3, 1'b0, 1'b1);  expect_out("t1.rd",   1'b0, 4'd0, 3'd0, 16'd0);
        idle(9); cmd(OP_PRE, 3'd3, 1'b0, 1'b1);  expect_out("t1.pre",  1'b0, 4'd0, 3'd0, 16'd0);
        idle(4); cmd(OP_ACT, 3'd3, 1'b0, 1'b1);  expect_out("t1.act2", 1'b0, 4'd0, 3'd0, 16'd0);
        idle(14); cmd(OP_PRE, 3'd3, 1'b0, 1'b1); expect_out("t1.pre2", 1'b0, 4'd0, 3'd0, 16'd0);

        // 2: tRCD at +4, pulse width, tCCD ok at +4, tCCD fail at +3
        cmd(OP_ACT, 3'd1, 1'b0, 1'b1);
        idle(3); cmd(OP_RD, 3'd1, 1'b0, 1'b1);   expect_out("t2.trcd",  1'b1, 4'd6, 3'd1, 16'd1);
        idle(1);                                  expect_out("t2.pulse", 1'b0, 4'd0, 3'd0, 16'd1);
        idle(2); cmd(OP_WR, 3'd1, 1'b0, 1'b1);   expect_out("t2.wr_ok", 1'b0, 4'd0, 3'd0, 16'd1);
        idle(2); cmd(OP_WR, 3'd1, 1'b0, 1'b1);   expect_out("t2.tccd",  1'b1, 4'd7, 3'd1, 16'd2);
        idle(3); cmd(OP_PRE, 3'd1, 1'b0, 1'b1);  expect_out("t2.pre",   1'b0, 4'd0, 3'd0, 16'd2);

        // 3: tRAS at +10, tRP at +3, ACT to open bank (codes 1 and 2 both fail),
        //    PRE-all with banks 2 and 6 both short of tRAS -> bank 2 reported
        cmd(OP_ACT, 3'd2, 1'b0, 1'b1);
        idle(9); cmd(OP_PRE, 3'd2, 1'b0, 1'b1);  expect_out("t3.tras",  1'b1, 4'd8, 3'd2, 16'd3);
        idle(2); cmd(OP_ACT, 3'd2, 1'b0, 1'b1);  expect_out("t3.trp",   1'b1, 4'd2, 3'd2, 16'd4);
        cmd(OP_ACT, 3'd2, 1'b0, 1'b1);           expect_out("t3.open",  1'b1, 4'd1, 3'd2, 16'd5);
        cmd(OP_ACT, 3'd6, 1'b0, 1'b1);           expect_out("t3.act6",  1'b0, 4'd0, 3'd0, 16'd5);
        idle(3); cmd(OP_PRE, 3'd5, 1'b1, 1'b1);  expect_out("t3.preall",1'b1, 4'd8, 3'd2, 16'd6);

        // 4: RD to IDLE bank, REF with bank open, REF-REF at +44, ACT at +20 after REF
        cmd(OP_RD, 3'd5, 1'b0, 1'b1);            expect_out("t4.notopen",1'b1, 4'd5, 3'd5, 16'd7);
        cmd(OP_ACT, 3'd4, 1'b0, 1'b1);           expect_out("t4.act4",  1'b0, 4'd0, 3'd0, 16'd7);
        idle(5); cmd(OP_REF, 3'd7, 1'b0, 1'b1);  expect_out("t4.refopen",1'b1, 4'd9, 3'd0, 16'd8);
        idle(8); cmd(OP_PRE, 3'd4, 1'b0, 1'b1);  expect_out("t4.pre4",  1'b0, 4'd0, 3'd0, 16'd8);
        idle(34); cmd(OP_REF, 3'd0, 1'b0, 1'b1); expect_out("t4.ref44", 1'b0, 4'd0, 3'd0, 16'd8);
        idle(19); cmd(OP_ACT, 3'd7, 1'b0, 1'b1); expect_out("t4.trfc",  1'b1, 4'd3, 3'd7, 16'd9);

        // 5: MRS with bank open, MRS at +2, REF right after PRE (tRP bank 7)
        cmd(OP_MRS, 3'd3, 1'b0, 1'b1);           expect_out("t5.mrsopen",1'b1, 4'd10, 3'd0, 16'd10);
        idle(1); cmd(OP_MRS, 3'd0, 1'b0, 1'b1);  expect_out("t5.tmrd",  1'b1, 4'd4, 3'd0, 16'd11);
        idle(11); cmd(OP_PRE, 3'd7, 1'b0, 1'b1); expect_out("t5.pre7",  1'b0, 4'd0, 3'd0, 16'd11);
        cmd(OP_REF, 3'd0, 1'b0, 1'b1);           expect_out("t5.reftrp",1'b1, 4'd2, 3'd7, 16'd12);

        // en=0: ACT is ignored, so a following RD finds the bank IDLE
        idle(5);
        cmd(OP_ACT, 3'd0, 1'b0, 1'b0);           expect_out("en0.act",  1'b0, 4'd0, 3'd0, 16'd12);
        cmd(OP_RD,  3'd0, 1'b0, 1'b1);           expect_out("en0.rd",   1'b1, 4'd5, 3'd0, 16'd13);

        // Saturation: 65536 further violating RDs
        for (int i = 0; i < 65536; i++) cmd(OP_RD, 3'd0, 1'b0, 1'b1);
        expect_out("sat", 1'b1, 4'd5, 3'd0, 16'hFFFF);
        cmd(OP_RD, 3'd0, 1'b0, 1'b1);
        chk("sat.hold", 32'(viol_count), 32'hFFFF);

        // 6: asynchronous reset during an active pulse with a bank open
        idle(10);
        cmd(OP_ACT, 3'd1, 1'b0, 1'b1);
        cs_n = 1'b0; {ras_n, cas_n, we_n} = OP_RD; ba = 3'd1;
        @(posedge clk);
        #2;
        cs_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111; ba = 3'd0;
        expect_out("t6.pulse", 1'b1, 4'd6, 3'd1, 16'hFFFF);
        rst_n = 1'b0;
        #1;
        expect_out("t6.async", 1'b0, 4'd0, 3'd0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cmd(OP_ACT, 3'd1, 1'b0, 1'b1);           expect_out("t6.act",   1'b0, 4'd0, 3'd0, 16'd0);
        cmd(OP_RD,  3'd1, 1'b0, 1'b1);           expect_out("t6.rd",    1'b1, 4'd6, 3'd1, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
